// File: rtl/cache_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// cache_lookup_ctrl
//
// Read-path controller for a direct-mapped, read-only cache. It drives the
// read port of the dual-port tag/data SRAM for lookups and the write port for
// refills. CPU word reads are tag-compared against the SRAM contents. A hit is
// answered from the SRAM line. A miss fetches the whole 64B line from memory,
// writes it into the SRAM and answers from the fill data. There is no dirty
// state and no write-back.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid_i/ready_o CPU read request handshake
//   req_addr_i          byte address; the low word-byte bits are ignored
//   rsp_valid_o         single-cycle response pulse (no backpressure)
//   rsp_data_o          response word
//   mem_req_valid_o     line-fetch request, held until mem_req_ready_i
//   mem_req_ready_i     memory accepts the fetch
//   mem_addr_o          line-aligned fetch address
//   mem_rsp_valid_i     single-beat fill valid (only honoured in MISS_WAIT)
//   mem_rsp_data_i      fill line
//   sram_rden_o/raddr_o SRAM read port request
//   sram_rtag_i/rdata_i SRAM read data, valid only the cycle after rden
//   sram_wren_o/waddr_o SRAM write port (refill)
//   sram_wtag_o         {valid=1, tag}
//   sram_wdata_o        fill line
//   hit_cnt_o           saturating hit counter
//   miss_cnt_o          saturating miss counter
// ---------------------------------------------------------------------------
module cache_lookup_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 9,
    parameter int OFFSET_W = 6,
    parameter int LINE_W   = 512,
    parameter int WORD_W   = 32,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,

    output logic                rsp_valid_o,
    output logic [WORD_W-1:0]   rsp_data_o,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic                mem_rsp_valid_i,
    input  logic [LINE_W-1:0]   mem_rsp_data_i,

    output logic                sram_rden_o,
    output logic [INDEX_W-1:0]  sram_raddr_o,
    input  logic [TAG_W:0]      sram_rtag_i,
    input  logic [LINE_W-1:0]   sram_rdata_i,

    output logic                sram_wren_o,
    output logic [INDEX_W-1:0]  sram_waddr_o,
    output logic [TAG_W:0]      sram_wtag_o,
    output logic [LINE_W-1:0]   sram_wdata_o,

    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
);

    // byte-within-word bits and word-within-line select width
    localparam int WBYTE_W = $clog2(WORD_W / 8);
    localparam int WSEL_W  = OFFSET_W - WBYTE_W;
    localparam int NWORDS  = LINE_W / WORD_W;

    // Latched request, byte-in-word bits dropped since they never matter.
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] idx;
        logic [WSEL_W-1:0]  word;
    } addr_t;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOOKUP    = 2'd1;
    localparam logic [1:0] S_MISS_REQ  = 2'd2;
    localparam logic [1:0] S_MISS_WAIT = 2'd3;

    logic [1:0]        state_q, state_d;
    addr_t             addr_q, addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    logic              lookup_hit;
    logic              fill_fire;
    logic              unused_bits;

    // Byte offset inside a word is deliberately ignored.
    assign unused_bits = &{1'b0, req_addr_i[WBYTE_W-1:0]};

    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0] w);
        logic [NWORDS-1:0][WORD_W-1:0] words;
        words = line;
        return words[w];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // SRAM read data is only meaningful in LOOKUP (the SRAM floats it
    // otherwise), so the hit decision is consumed only in that state.
    assign lookup_hit = sram_rtag_i[TAG_W] && (sram_rtag_i[TAG_W-1:0] == addr_q.tag);

    // Refill fires in the same cycle as the memory beat. Gated by rst_n so a
    // beat arriving while reset is asserted never corrupts the array.
    assign fill_fire = rst_n && (state_q == S_MISS_WAIT) && mem_rsp_valid_i;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = rsp_data_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = addr_t'(req_addr_i[ADDR_W-1:WBYTE_W]);
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = word_sel(sram_rdata_i, addr_q.word);
                    hit_cnt_d   = sat_inc(hit_cnt_q);
                    state_d     = S_IDLE;
                end else begin
                    miss_cnt_d      = sat_inc(miss_cnt_q);
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = {addr_q.tag, addr_q.idx, {OFFSET_W{1'b0}}};
                    state_d         = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                // valid/addr stay registered and stable until accepted
                if (mem_req_ready_i) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                if (mem_rsp_valid_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = word_sel(mem_rsp_data_i, addr_q.word);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
        end
    end

    // Request side: only IDLE accepts; the read is launched combinationally so
    // the tag/data arrive exactly in LOOKUP.
    assign req_ready_o     = (state_q == S_IDLE);
    assign sram_rden_o     = (state_q == S_IDLE) && req_valid_i;
    assign sram_raddr_o    = req_addr_i[OFFSET_W +: INDEX_W];

    // Refill port. A later read of the same set can only be issued from IDLE,
    // i.e. after this write has landed, so read/write never collide.
    assign sram_wren_o     = fill_fire;
    assign sram_waddr_o    = addr_q.idx;
    assign sram_wtag_o     = {1'b1, addr_q.tag};
    assign sram_wdata_o    = mem_rsp_data_i;

    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_addr_o      = mem_addr_q;
    assign hit_cnt_o       = hit_cnt_q;
    assign miss_cnt_o      = miss_cnt_q;

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Bench for cache_lookup_ctrl: directed scenarios followed by random reads,
// checked against a set-level tag model and an address-derived memory image.
module tb_cache_lookup_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [31:0]  req_addr_i;
    logic         rsp_valid_o;
    logic [31:0]  rsp_data_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [31:0]  mem_addr_o;
    logic         mem_rsp_valid_i;
    logic [511:0] mem_rsp_data_i;
    logic         sram_rden_o;
    logic [8:0]   sram_raddr_o;
    logic [17:0]  sram_rtag_i;
    logic [511:0] sram_rdata_i;
    logic         sram_wren_o;
    logic [8:0]   sram_waddr_o;
    logic [17:0]  sram_wtag_o;
    logic [511:0] sram_wdata_o;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    always #5 clk = ~clk;

    cache_lookup_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i(mem_rsp_data_i),
        .sram_rden_o(sram_rden_o), .sram_raddr_o(sram_raddr_o),
        .sram_rtag_i(sram_rtag_i), .sram_rdata_i(sram_rdata_i),
        .sram_wren_o(sram_wren_o), .sram_waddr_o(sram_waddr_o),
        .sram_wtag_o(sram_wtag_o), .sram_wdata_o(sram_wdata_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    // ---- SRAM array model: registered read, junk outside the read cycle ----
    logic [17:0]  s_tag  [512];
    logic [511:0] s_data [512];
    logic         rd_vld;
    logic [17:0]  rtag_r;
    logic [511:0] rdata_r;
    logic [31:0]  junk;

    always @(posedge clk) begin
        junk   <= $urandom;
        rd_vld <= sram_rden_o;
        if (sram_rden_o) begin
            rtag_r  <= s_tag[sram_raddr_o];
            rdata_r <= s_data[sram_raddr_o];
        end
        if (!rst_n) begin
            for (int i = 0; i < 512; i++) s_tag[i] <= '0;
        end else if (sram_wren_o) begin
            s_tag[sram_waddr_o]  <= sram_wtag_o;
            s_data[sram_waddr_o] <= sram_wdata_o;
        end
    end

    assign sram_rtag_i  = rd_vld ? rtag_r  : junk[17:0];
    assign sram_rdata_i = rd_vld ? rdata_r : {16{junk}};

    // ---- reference model ----
    int          total = 0;
    int          bad   = 0;
    bit          ref_v [512];
    logic [16:0] ref_t [512];
    int          ref_hit  = 0;
    int          ref_miss = 0;

    // Memory image: word i of line L; line 0x1040 holds 0xA000_0000+i.
    function automatic logic [31:0] mem_word(input logic [31:0] ln, input int i);
        return 32'hA000_0000 + 32'(i) + ((ln - 32'h0000_1040) << 2);
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] ln);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = mem_word(ln, i);
        return r;
    endfunction

    task automatic check(input string nm, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 512; i++) ref_v[i] = 1'b0;
        ref_hit  = 0;
        ref_miss = 0;
    endtask

    // One complete read transaction, starting and ending in IDLE.
    task automatic do_read(input logic [31:0] a, input int rdy_lat, input int rsp_lat);
        int           idx;
        int           w;
        logic [16:0]  tg;
        logic [31:0]  ln;
        logic [511:0] ld;
        bit           hit;
        idx = int'((a >> 6) % 512);
        w   = int'((a >> 2) % 16);
        tg  = 17'(a >> 15);
        ln  = a & ~32'h3F;
        ld  = line_of(ln);
        hit = ref_v[idx] && (ref_t[idx] == tg);

        check("idle_ready", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        #1;
        check("rden", sram_rden_o, 1);
        check("raddr", sram_raddr_o, idx);
        tick();
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        check("lookup_ready", req_ready_o, 0);
        check("lookup_no_rsp", rsp_valid_o, 0);
        tick();
        if (hit) begin
            ref_hit++;
            check("hit_rsp_valid", rsp_valid_o, 1);
            check("hit_data", rsp_data_o, mem_word(ln, w));
            check("hit_no_mreq", mem_req_valid_o, 0);
        end else begin
            ref_miss++;
            check("miss_no_rsp", rsp_valid_o, 0);
            check("mreq_valid", mem_req_valid_o, 1);
            check("mreq_addr", mem_addr_o, ln);
            for (int k = 0; k < rdy_lat; k++) begin
                // stray fill beats outside MISS_WAIT must be ignored
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = ~ld;
                #1;
                check("stray_no_wren", sram_wren_o, 0);
                tick();
                check("mreq_hold_valid", mem_req_valid_o, 1);
                check("mreq_hold_addr", mem_addr_o, ln);
                check("mreq_hold_ready", req_ready_o, 0);
                check("mreq_hold_no_rsp", rsp_valid_o, 0);
            end
            mem_rsp_valid_i = 1'b0;
            mem_req_ready_i = 1'b1;
            tick();
            mem_req_ready_i = 1'b0;
            check("mreq_drop", mem_req_valid_o, 0);
            for (int k = 0; k < rsp_lat; k++) begin
                tick();
                check("wait_no_rsp", rsp_valid_o, 0);
                check("wait_ready", req_ready_o, 0);
            end
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = ld;
            #1;
            check("fill_wren", sram_wren_o, 1);
            check("fill_waddr", sram_waddr_o, idx);
            check("fill_wtag", sram_wtag_o, {1'b1, tg});
            check("fill_wdata", sram_wdata_o, ld);
            tick();
            mem_rsp_valid_i = 1'b0;
            check("miss_rsp_valid", rsp_valid_o, 1);
            check("miss_data", rsp_data_o, mem_word(ln, w));
            ref_v[idx] = 1'b1;
            ref_t[idx] = tg;
        end
        check("hit_cnt", hit_cnt_o, ref_hit);
        check("miss_cnt", miss_cnt_o, ref_miss);
        check("back_idle", req_ready_o, 1);
    endtask

    initial begin
        logic [31:0] a;
        int          n;

        rst_n           = 1'b0;
        req_valid_i     = 1'b0;
        req_addr_i      = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_data", rsp_data_o, 0);
        check("rst_mreq", mem_req_valid_o, 0);
        check("rst_maddr", mem_addr_o, 0);
        check("rst_wren", sram_wren_o, 0);
        check("rst_hit", hit_cnt_o, 0);
        check("rst_miss", miss_cnt_o, 0);
        check("rst_ready", req_ready_o, 1);

        // 1: cold miss on 0x1044
        do_read(32'h0000_1044, 0, 1);
        check("t1_data", rsp_data_o, 32'hA000_0001);
        check("t1_miss", miss_cnt_o, 1);

        // 2: same address hits
        do_read(32'h0000_1044, 0, 0);
        check("t2_data", rsp_data_o, 32'hA000_0001);
        check("t2_hit", hit_cnt_o, 1);

        // 3: conflicting tag evicts, original misses again
        do_read(32'h0004_1044, 0, 2);
        do_read(32'h0000_1044, 0, 0);
        check("t3_miss", miss_cnt_o, 3);

        // 4: memory stalls the fetch for 5 cycles
        do_read(32'h0000_2088, 5, 1);

        // 5: reset while waiting for the fill
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0008_1044;
        tick();
        req_valid_i = 1'b0;
        tick();
        check("t5_mreq", mem_req_valid_o, 1);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        check("t5_mreq_drop", mem_req_valid_o, 0);
        check("t5_ready", req_ready_o, 1);
        check("t5_cnt_clr", miss_cnt_o, 0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = line_of(32'h0008_1040);
        #1;
        check("t5_no_wren", sram_wren_o, 0);
        tick();
        mem_rsp_valid_i = 1'b0;
        check("t5_no_rsp", rsp_valid_o, 0);
        do_read(32'h0008_1044, 0, 0);
        check("t5_miss_again", miss_cnt_o, 1);

        // 6: back-to-back hits with req_valid held
        n = 6;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0008_1044;
        for (int i = 0; i < n; i++) begin
            tick();
            check("b2b_gap_rsp", rsp_valid_o, 0);
            check("b2b_gap_ready", req_ready_o, 0);
            tick();
            ref_hit++;
            check("b2b_rsp", rsp_valid_o, 1);
            check("b2b_data", rsp_data_o, mem_word(32'h0008_1040, 1));
            check("b2b_hit_cnt", hit_cnt_o, ref_hit);
            check("b2b_ready", req_ready_o, 1);
            if (i == n - 1) req_valid_i = 1'b0;
        end

        // random reads over a few sets and tags to mix hits and conflicts
        for (int t = 0; t < 80; t++) begin
            logic [31:0] idx;
            case ($urandom_range(0, 3))
                0:       idx = 32'h041;
                1:       idx = 32'h042;
                2:       idx = 32'h1FF;
                default: idx = 32'h000;
            endcase
            a = (32'($urandom_range(0, 3)) << 15) | (idx << 6)
              | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                tick();
                check("gap_no_rsp", rsp_valid_o, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
